// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared definitions for the bus transfer sequencer: FSM state encoding,
// default geometry and a small state classification helper.
package bus_transfer_sequencer_pkg;

   localparam int DEF_N_REGS     = 8;
   localparam int DEF_ID_W       = 3;
   localparam int DEF_SETTLE_CYC = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRIVE   = 3'd1,
      ST_LATCH   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_REJECT  = 3'd4
   } state_t;

   // Source output_enable is held through the whole drive/latch window.
   function automatic logic drives_bus(input state_t s);
      return (s == ST_DRIVE) || (s == ST_LATCH);
   endfunction

endpackage

// File: rtl/bus_transfer_sequencer_onehot_decoder.sv
// Id to one-hot strobe decoder with enable; ids at or beyond N_OUT decode
// to all zeros, matching 1<<id truncated to N_OUT bits.
module onehot_decoder #(
   parameter int ID_W  = 3,
   parameter int N_OUT = 8
) (
   input  logic              en,
   input  logic [ID_W-1:0]   id,
   output logic [N_OUT-1:0]  onehot
);

   // Compare the id against every bit position.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_OUT; i++) begin
         onehot[i] = en && (id == ID_W'(i));
      end
   end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences source drive / destination latch strobes on the shared tri-state
// bus for one accepted transfer at a time, rejecting unsafe requests.
module bus_transfer_sequencer
   import bus_transfer_sequencer_pkg::*;
#(
   parameter int N_REGS     = DEF_N_REGS,
   parameter int ID_W       = DEF_ID_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ID_W-1:0]   req_src,
   input  logic [ID_W-1:0]   req_dst,
   output logic [N_REGS-1:0] output_enable,
   output logic [N_REGS-1:0] input_enable,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int               CNT_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [ID_W-1:0]     src_r, src_s, dst_r, dst_s;
   logic [N_REGS-1:0]   oe_r, ie_r, oe_dec_s, ie_dec_s;
   logic                done_r, err_r;
   logic                accept_s, bad_s;

   // Next-state, settle counter and request capture.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      src_s    = src_r;
      dst_s    = dst_r;
      accept_s = req_valid && (state_r == ST_IDLE);
      bad_s    = (32'(req_src) >= N_REGS) || (32'(req_dst) >= N_REGS) ||
                 (req_src == req_dst);
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               src_s   = req_src;
               dst_s   = req_dst;
               cnt_s   = '0;
               state_s = bad_s ? ST_REJECT : ST_DRIVE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s   = '0;
               state_s = ST_LATCH;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
            end
         end
         ST_LATCH:   state_s = ST_RELEASE;
         ST_RELEASE: state_s = ST_IDLE;
         ST_REJECT:  state_s = ST_IDLE;
         default:    state_s = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they register in step with it.
   onehot_decoder #(.ID_W(ID_W), .N_OUT(N_REGS)) u_src_dec (
      .en     (drives_bus(state_s)),
      .id     (src_s),
      .onehot (oe_dec_s)
   );

   onehot_decoder #(.ID_W(ID_W), .N_OUT(N_REGS)) u_dst_dec (
      .en     (state_s == ST_LATCH),
      .id     (dst_s),
      .onehot (ie_dec_s)
   );

   // State, counter, captured ids and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         src_r   <= '0;
         dst_r   <= '0;
         oe_r    <= '0;
         ie_r    <= '0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         src_r   <= src_s;
         dst_r   <= dst_s;
         oe_r    <= oe_dec_s;
         ie_r    <= ie_dec_s;
         done_r  <= (state_s == ST_RELEASE) || (state_s == ST_REJECT);
         err_r   <= (state_s == ST_REJECT);
      end
   end

   assign req_ready     = (state_r == ST_IDLE);
   assign busy          = (state_r != ST_IDLE);
   assign output_enable = oe_r;
   assign input_enable  = ie_r;
   assign done          = done_r;
   assign err           = err_r;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: directed and random transfers on two sequencer
// instances (settle 1 with 4-bit ids, settle 3 with 3-bit ids).
module tb_bus_transfer_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       v1, r1, b1, dn1, e1;
   logic [3:0] s1, d1;
   logic [7:0] oe1, ie1;
   logic       v3, r3, b3, dn3, e3;
   logic [2:0] s3, d3;
   logic [7:0] oe3, ie3;

   int n_checks = 0;
   int n_fail   = 0;
   bit armed    = 1'b0;

   bus_transfer_sequencer #(.N_REGS(8), .ID_W(4), .SETTLE_CYC(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1),
      .req_src(s1), .req_dst(d1), .output_enable(oe1), .input_enable(ie1),
      .busy(b1), .done(dn1), .err(e1)
   );

   bus_transfer_sequencer #(.N_REGS(8), .ID_W(3), .SETTLE_CYC(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(v3), .req_ready(r3),
      .req_src(s3), .req_dst(d3), .output_enable(oe3), .input_enable(ie3),
      .busy(b3), .done(dn3), .err(e3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_inv(input string tag, input logic [7:0] oe, input logic [7:0] ie);
      chk({tag, "_oe_pop"}, 32'($countones(oe) <= 1), 32'd1);
      chk({tag, "_ie_pop"}, 32'($countones(ie) <= 1), 32'd1);
      chk({tag, "_ie_needs_oe"}, 32'((ie == 8'h00) || (oe != 8'h00)), 32'd1);
      chk({tag, "_overlap"}, 32'(oe & ie), 32'd0);
   endtask

   // Bus-safety invariants on both instances every cycle.
   always @(negedge clk) begin
      if (armed) begin
         chk_inv("inv1", oe1, ie1);
         chk_inv("inv3", oe3, ie3);
      end
   end

   task automatic sample(input bit sel, output logic [7:0] oe, output logic [7:0] ie,
                         output logic dn, output logic er, output logic bz, output logic rd);
      if (sel) begin
         oe = oe3; ie = ie3; dn = dn3; er = e3; bz = b3; rd = r3;
      end else begin
         oe = oe1; ie = ie1; dn = dn1; er = e1; bz = b1; rd = r1;
      end
   endtask

   // One transfer checked against the expected per-cycle strobe trace.
   task automatic xfer(input bit sel, input int src, input int dst, input bit hold);
      int         settle;
      bit         rej;
      int         len;
      logic [7:0] oe, ie, x_oe, x_ie;
      logic       dn, er, bz, rd, x_dn, x_er;
      settle = sel ? 3 : 1;
      rej    = (src >= 8) || (dst >= 8) || (src == dst);
      len    = rej ? 1 : settle + 2;
      @(negedge clk);
      sample(sel, oe, ie, dn, er, bz, rd);
      chk("idle_ready", 32'(rd), 32'd1);
      chk("idle_busy", 32'(bz), 32'd0);
      chk("idle_done", 32'(dn), 32'd0);
      chk("idle_oe", 32'(oe), 32'd0);
      if (sel) begin
         v3 = 1'b1; s3 = src[2:0]; d3 = dst[2:0];
      end else begin
         v1 = 1'b1; s1 = src[3:0]; d1 = dst[3:0];
      end
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         x_oe = 8'h00; x_ie = 8'h00; x_dn = 1'b0; x_er = 1'b0;
         if (rej) begin
            x_dn = 1'b1; x_er = 1'b1;
         end else if (k < settle) begin
            x_oe = 8'(1 << src);
         end else if (k == settle) begin
            x_oe = 8'(1 << src); x_ie = 8'(1 << dst);
         end else begin
            x_dn = 1'b1;
         end
         sample(sel, oe, ie, dn, er, bz, rd);
         chk("xfer_oe", 32'(oe), 32'(x_oe));
         chk("xfer_ie", 32'(ie), 32'(x_ie));
         chk("xfer_done", 32'(dn), 32'(x_dn));
         chk("xfer_err", 32'(er), 32'(x_er));
         chk("xfer_busy", 32'(bz), 32'd1);
         chk("xfer_ready", 32'(rd), 32'd0);
         // Inputs must be ignored while the transfer is in flight.
         if (sel) begin
            s3 = 3'($urandom_range(0, 7)); d3 = 3'($urandom_range(0, 7));
         end else begin
            s1 = 4'($urandom_range(0, 15)); d1 = 4'($urandom_range(0, 15));
         end
      end
      if (!hold) begin
         v1 = 1'b0; v3 = 1'b0;
      end
   endtask

   initial begin
      int src, dst;
      reset = 1'b1;
      v1 = 1'b0; s1 = 4'd0; d1 = 4'd0;
      v3 = 1'b0; s3 = 3'd0; d3 = 3'd0;
      repeat (3) @(negedge clk);
      armed = 1'b1;
      chk("rst_oe", 32'(oe1), 32'd0);
      chk("rst_done", 32'(dn1), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_oe1", 32'(oe1), 32'd0);
         chk("idle_ie1", 32'(ie1), 32'd0);
         chk("idle_rdy1", 32'(r1), 32'd1);
         chk("idle_done1", 32'(dn1), 32'd0);
         chk("idle_rdy3", 32'(r3), 32'd1);
      end

      xfer(1'b0, 2, 5, 1'b0);
      xfer(1'b0, 3, 3, 1'b0);
      xfer(1'b0, 9, 1, 1'b0);
      xfer(1'b0, 1, 12, 1'b0);

      xfer(1'b0, 1, 4, 1'b1);
      xfer(1'b0, 7, 0, 1'b1);
      xfer(1'b0, 6, 2, 1'b0);

      // Reset while the destination is latching.
      @(negedge clk);
      v1 = 1'b1; s1 = 4'd1; d1 = 4'd6;
      @(negedge clk);
      chk("rl_drive_oe", 32'(oe1), 32'h02);
      @(negedge clk);
      chk("rl_latch_ie", 32'(ie1), 32'h40);
      reset = 1'b1; v1 = 1'b0;
      @(negedge clk);
      chk("rl_oe", 32'(oe1), 32'd0);
      chk("rl_ie", 32'(ie1), 32'd0);
      chk("rl_busy", 32'(b1), 32'd0);
      chk("rl_ready", 32'(r1), 32'd1);
      chk("rl_done", 32'(dn1), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rl_no_done", 32'(dn1), 32'd0);
         chk("rl_idle", 32'(b1), 32'd0);
      end

      xfer(1'b1, 2, 5, 1'b0);
      xfer(1'b1, 4, 4, 1'b0);
      xfer(1'b1, 0, 7, 1'b1);
      xfer(1'b1, 7, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         src = $urandom_range(0, 15);
         dst = ($urandom_range(0, 5) == 0) ? src : $urandom_range(0, 15);
         xfer(1'b0, src, dst, 1'($urandom_range(0, 1)));
      end
      xfer(1'b0, 0, 1, 1'b0);

      for (int i = 0; i < 15; i++) begin
         src = $urandom_range(0, 7);
         dst = $urandom_range(0, 7);
         xfer(1'b1, src, dst, 1'($urandom_range(0, 1)));
      end
      xfer(1'b1, 3, 6, 1'b0);

      @(negedge clk);
      armed = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
